// File: rtl/sip_neuron_scheduler.sv
// sip_neuron_scheduler
//   Time-shares one Synaptic_Input_Processor (SIP/LIF) across NUM_NEURONS
//   logical neurons. Each accepted 16-bit presynaptic spike frame is replayed
//   through the SIP once per neuron: fetch the neuron's packed 16x4-bit weight
//   row, present weights/spikes/Ein, pulse load, then wait for flush_spike
//   (or a timeout) and record the neuron's output spike. The collected spike
//   vector is handed downstream under valid/ready.
//
// Ports
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   frame_valid/ready    : upstream frame handshake (ready only in IDLE)
//   frame_spikes,ein_mask: frame data, latched on accept
//   mem_rd_en, mem_addr  : synapse memory read (addr = neuron index)
//   mem_rdata            : weight row, valid the cycle after mem_rd_en
//   sip_weight/spike_in/ein, sip_load : SIP drive, load is a 1-cycle pulse
//   sip_flush_spike, sip_spike        : SIP completion and output spike
//   out_valid/ready, out_spikes       : result handshake, bit n = neuron n
//   busy                 : any state other than IDLE
//   timeout_err          : sticky, set when a neuron is abandoned
module sip_neuron_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic [15:0]            frame_spikes,
    input  logic [15:0]            ein_mask,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [63:0]            mem_rdata,
    output logic [63:0]            sip_weight,
    output logic [15:0]            sip_spike_in,
    output logic [15:0]            sip_ein,
    output logic                   sip_load,
    input  logic                   sip_flush_spike,
    input  logic                   sip_spike,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] out_spikes,
    output logic                   busy,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_MEM, S_LOAD, S_WAIT_SIP, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_N   = ADDR_W'(NUM_NEURONS - 1);
    // Timeout fires in the WAIT_SIP cycle whose increment brings the count
    // to TIMEOUT, so a silent SIP costs exactly TIMEOUT WAIT_SIP cycles.
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT - 1);

    state_t              state, next_state;
    logic [ADDR_W-1:0]   n;
    logic [15:0]         cnt;
    logic [15:0]         frame_q;
    logic [15:0]         ein_q;

    logic accept;
    logic tmo_hit;
    logic wait_done;

    assign accept    = frame_valid & frame_ready;
    assign tmo_hit   = (cnt == TMO_LAST);
    assign wait_done = sip_flush_spike | tmo_hit;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (accept) next_state = S_FETCH;
            S_FETCH:    next_state = S_WAIT_MEM;
            S_WAIT_MEM: next_state = S_LOAD;
            S_LOAD:     next_state = S_WAIT_SIP;
            S_WAIT_SIP: if (wait_done) next_state = (n == LAST_N) ? S_DONE : S_FETCH;
            S_DONE:     if (out_ready) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output decode (state-only; no input-to-output paths)
    always_comb begin
        frame_ready = 1'b0;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        sip_load    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE: begin
                frame_ready = 1'b1;
                busy        = 1'b0;
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = n;
            end
            S_LOAD:  sip_load  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: frame latch, SIP drive registers, neuron index, timeout
    // counter and result collection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n            <= '0;
            cnt          <= '0;
            frame_q      <= '0;
            ein_q        <= '0;
            sip_weight   <= '0;
            sip_spike_in <= '0;
            sip_ein      <= '0;
            out_spikes   <= '0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        frame_q    <= frame_spikes;
                        ein_q      <= ein_mask;
                        out_spikes <= '0;
                        n          <= '0;
                    end
                end
                S_WAIT_MEM: begin
                    // SIP buses only change here, so they hold from LOAD
                    // through WAIT_SIP and the following FETCH.
                    sip_weight   <= mem_rdata;
                    sip_spike_in <= frame_q;
                    sip_ein      <= ein_q;
                end
                S_LOAD: cnt <= '0;
                S_WAIT_SIP: begin
                    cnt <= cnt + 16'd1;
                    if (sip_spike)
                        out_spikes <= out_spikes | (NUM_NEURONS'(1) << n);
                    // A flush on the timeout cycle wins: no error.
                    if (tmo_hit && !sip_flush_spike)
                        timeout_err <= 1'b1;
                    if (wait_done && (n != LAST_N))
                        n <= n + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
